// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multi-cycle instruction sequencer. Each instruction is walked through
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> RETIRE, with optional IRQ
//   entry after RETIRE. The unit drives one-hot-ish strobes to the datapath,
//   register file, data memory and I/O ports.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   controle            instruction control field (class/i/s/load/link/func)
//   irq, irq_enable     level interrupt request and its enable
//   io_in_valid         input device has data
//   io_out_ready        output device accepts data
//   ir_write            latch instruction (FETCH)
//   pc_inc, jump        PC update on retire (sequential / branch target)
//   alu_sel             ALU operation (0100 = pass/ADD when idle)
//   reg_write, mem_write, mem_to_reg   register-file / memory strobes
//   link, s, i          pass-through of controle[5], [7], [8]
//   io_in_ready, io_out_valid          I/O handshakes
//   rbaselim_write, interrupt_write, finish_interrupt  system-op strobes
//   irq_ack             interrupt entry strobe
//   illegal_op          undefined opcode strobe (on RETIRE)
//   busy                state != FETCH
module multicycle_control_unit #(
    parameter int CTRL_W     = 11,
    parameter int SEL_W      = 4,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CTRL_W-1:0] controle,
    input  logic              irq,
    input  logic              irq_enable,
    input  logic              io_in_valid,
    input  logic              io_out_ready,
    output logic              ir_write,
    output logic              pc_inc,
    output logic              jump,
    output logic [SEL_W-1:0]  alu_sel,
    output logic              reg_write,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              link,
    output logic              s,
    output logic              i,
    output logic              io_in_ready,
    output logic              io_out_valid,
    output logic              rbaselim_write,
    output logic              interrupt_write,
    output logic              finish_interrupt,
    output logic              irq_ack,
    output logic              illegal_op,
    output logic              busy
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB,
        S_IO_IN, S_IO_OUT, S_RETIRE, S_IRQ
    } state_t;

    localparam logic [1:0] C_ALU = 2'b00;
    localparam logic [1:0] C_MEM = 2'b01;
    localparam logic [1:0] C_BR  = 2'b10;
    localparam logic [1:0] C_SYS = 2'b11;

    localparam logic [3:0] F_TST  = 4'b1000;
    localparam logic [3:0] F_CMP  = 4'b1010;
    localparam logic [3:0] F_MUL  = 4'b1110;
    localparam logic [3:0] F_UDIV = 4'b1111;

    localparam logic [3:0] F_NOP  = 4'b0000;
    localparam logic [3:0] F_IN   = 4'b0001;
    localparam logic [3:0] F_OUT  = 4'b0010;
    localparam logic [3:0] F_FIN  = 4'b0011;
    localparam logic [3:0] F_SBL  = 4'b0100;
    localparam logic [3:0] F_SIR  = 4'b0101;

    localparam logic [SEL_W-1:0] ALU_PASS = SEL_W'(4'b0100);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cls_q;
    logic [3:0]       fn_q;
    logic             ld_q;
    logic             ill_q;

    logic [1:0]       cls_d;
    logic [3:0]       fn_d;
    logic             legal_d;
    logic             ctrl_unused;

    assign cls_d = controle[CTRL_W-1 -: 2];
    assign fn_d  = controle[3:0];
    assign link  = controle[5];
    assign s     = controle[7];
    assign i     = controle[8];
    assign busy  = (state != S_FETCH);
    assign ctrl_unused = controle[4];

    function automatic logic is_legal(input logic [1:0] c, input logic [3:0] f);
        logic ok;
        ok = 1'b1;
        if (c == C_ALU)
            ok = !(f == 4'b0000 || f == 4'b0100 || f == 4'b1001 || f == 4'b1011);
        else if (c == C_SYS)
            ok = (f <= F_SIR);
        return ok;
    endfunction

    function automatic logic [SEL_W-1:0] alu_enc(input logic [3:0] f);
        logic [SEL_W-1:0] a;
        case (f)
            4'b0001, 4'b1000: a = SEL_W'(4'b0000);   // AND, TST
            4'b0010:          a = SEL_W'(4'b0001);   // EOR
            4'b0011, 4'b1010: a = SEL_W'(4'b0011);   // SUB, CMP
            4'b1100:          a = SEL_W'(4'b0010);   // ORR
            4'b1110:          a = SEL_W'(4'b0101);   // MUL
            4'b1111:          a = SEL_W'(4'b0110);   // UDIV
            default:          a = ALU_PASS;          // ADD, MRS, MSR, MOV
        endcase
        return a;
    endfunction

    assign legal_d = is_legal(cls_d, fn_d);

    // Sequencer. Class/func are captured in DECODE so the strobes of later
    // states depend only on registered state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_FETCH;
            cnt   <= '0;
            cls_q <= '0;
            fn_q  <= '0;
            ld_q  <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    cls_q <= cls_d;
                    fn_q  <= fn_d;
                    ld_q  <= controle[6];
                    ill_q <= !legal_d;
                    cnt   <= '0;
                    if (!legal_d) begin
                        state <= S_RETIRE;
                    end else begin
                        case (cls_d)
                            C_ALU: begin
                                state <= S_EXEC;
                                if (fn_d == F_MUL)
                                    cnt <= CNT_W'(MUL_CYCLES - 1);
                                else if (fn_d == F_UDIV)
                                    cnt <= CNT_W'(DIV_CYCLES - 1);
                            end
                            C_SYS: begin
                                case (fn_d)
                                    F_NOP:   state <= S_RETIRE;
                                    F_IN:    state <= S_IO_IN;
                                    F_OUT:   state <= S_IO_OUT;
                                    default: state <= S_EXEC;
                                endcase
                            end
                            default: state <= S_EXEC;
                        endcase
                    end
                end
                S_EXEC: begin
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else if (cls_q == C_ALU)
                        state <= S_WB;
                    else if (cls_q == C_MEM)
                        state <= S_MEM;
                    else
                        state <= S_RETIRE;
                end
                S_MEM:    state <= ld_q ? S_WB : S_RETIRE;
                S_WB:     state <= S_RETIRE;
                S_IO_IN:  if (io_in_valid)  state <= S_RETIRE;
                S_IO_OUT: if (io_out_ready) state <= S_RETIRE;
                // Interrupts are only taken at the instruction boundary.
                S_RETIRE: state <= (irq && irq_enable) ? S_IRQ : S_FETCH;
                S_IRQ:    state <= S_FETCH;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Strobe decode. Reset masks everything so an aborted instruction emits
    // nothing on the reset cycle. IN's reg_write follows io_in_valid so the
    // register file captures data in the handshake cycle itself.
    always_comb begin
        ir_write         = 1'b0;
        pc_inc           = 1'b0;
        jump             = 1'b0;
        alu_sel          = ALU_PASS;
        reg_write        = 1'b0;
        mem_write        = 1'b0;
        mem_to_reg       = 1'b0;
        io_in_ready      = 1'b0;
        io_out_valid     = 1'b0;
        rbaselim_write   = 1'b0;
        interrupt_write  = 1'b0;
        finish_interrupt = 1'b0;
        irq_ack          = 1'b0;
        illegal_op       = 1'b0;
        if (reset) begin
            alu_sel = '0;
        end else begin
            case (state)
                S_FETCH: ir_write = 1'b1;
                S_EXEC: begin
                    if (cls_q == C_ALU)
                        alu_sel = alu_enc(fn_q);
                    if (cls_q == C_SYS) begin
                        finish_interrupt = (fn_q == F_FIN);
                        rbaselim_write   = (fn_q == F_SBL);
                        interrupt_write  = (fn_q == F_SIR);
                    end
                end
                S_MEM: begin
                    mem_to_reg = ld_q;
                    mem_write  = !ld_q;
                end
                S_WB: begin
                    mem_to_reg = (cls_q == C_MEM);
                    reg_write  = (cls_q == C_MEM) || !(fn_q == F_TST || fn_q == F_CMP);
                end
                S_IO_IN: begin
                    io_in_ready = 1'b1;
                    reg_write   = io_in_valid;
                end
                S_IO_OUT: io_out_valid = 1'b1;
                S_RETIRE: begin
                    jump       = (cls_q == C_BR) && !ill_q;
                    pc_inc     = !((cls_q == C_BR) && !ill_q);
                    illegal_op = ill_q;
                end
                S_IRQ:   irq_ack = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus pushes the expected
// per-cycle output vector of each instruction; a negedge monitor pops and
// compares every cycle while checking is enabled.
module tb_multicycle_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] controle = '0;
    logic        irq = 1'b0, irq_enable = 1'b0, io_in_valid = 1'b0, io_out_ready = 1'b0;
    logic        ir_write, pc_inc, jump, reg_write, mem_write, mem_to_reg;
    logic        link, s, i, io_in_ready, io_out_valid;
    logic        rbaselim_write, interrupt_write, finish_interrupt, irq_ack, illegal_op, busy;
    logic [3:0]  alu_sel;

    multicycle_control_unit dut (
        .clock(clock), .reset(reset), .controle(controle), .irq(irq),
        .irq_enable(irq_enable), .io_in_valid(io_in_valid), .io_out_ready(io_out_ready),
        .ir_write(ir_write), .pc_inc(pc_inc), .jump(jump), .alu_sel(alu_sel),
        .reg_write(reg_write), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .link(link), .s(s), .i(i), .io_in_ready(io_in_ready), .io_out_valid(io_out_valid),
        .rbaselim_write(rbaselim_write), .interrupt_write(interrupt_write),
        .finish_interrupt(finish_interrupt), .irq_ack(irq_ack),
        .illegal_op(illegal_op), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef logic [20:0] vec_t;
    localparam vec_t PI   = vec_t'(1) << 20;
    localparam vec_t PS   = vec_t'(1) << 19;
    localparam vec_t PL   = vec_t'(1) << 18;
    localparam vec_t IRW  = vec_t'(1) << 17;
    localparam vec_t PC   = vec_t'(1) << 16;
    localparam vec_t JMP  = vec_t'(1) << 15;
    localparam vec_t RW   = vec_t'(1) << 14;
    localparam vec_t MW   = vec_t'(1) << 13;
    localparam vec_t M2R  = vec_t'(1) << 12;
    localparam vec_t IRDY = vec_t'(1) << 11;
    localparam vec_t OVAL = vec_t'(1) << 10;
    localparam vec_t RBL  = vec_t'(1) << 9;
    localparam vec_t INTW = vec_t'(1) << 8;
    localparam vec_t FIN  = vec_t'(1) << 7;
    localparam vec_t ACK  = vec_t'(1) << 6;
    localparam vec_t ILL  = vec_t'(1) << 5;
    localparam vec_t BSY  = vec_t'(1) << 4;
    localparam vec_t F    = IRW | vec_t'(4);   // FETCH cycle

    vec_t  act, mon_e, cur_pt;
    vec_t  q[$];
    int    n_cmp = 0, n_bad = 0;
    bit    chk_en = 1'b0;
    string tname = "reset";

    assign act = {i, s, link, ir_write, pc_inc, jump, reg_write, mem_write, mem_to_reg,
                  io_in_ready, io_out_valid, rbaselim_write, interrupt_write,
                  finish_interrupt, irq_ack, illegal_op, busy, alu_sel};

    // Monitor: one expected vector per checked cycle.
    always @(negedge clock) begin
        if (chk_en) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL %s underflow: got %h, no expectation queued", tname, act);
            end else begin
                mon_e = q.pop_front();
                if (act !== mon_e) begin
                    n_bad++;
                    $display("FAIL %s cycle vector: got %h want %h", tname, act, mon_e);
                end
            end
        end
    end

    function automatic vec_t b(input vec_t flags, input logic [3:0] a);
        return flags | BSY | vec_t'(a);
    endfunction

    task automatic push(input vec_t v, input int n = 1);
        for (int k = 0; k < n; k++) q.push_back(v | cur_pt);
    endtask

    task automatic check_drained();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL %s leftover: got %0d queued, want 0", tname, q.size());
        end
        q.delete();
    endtask

    task automatic drive(input int k, input int vin, input int vout, input int virq);
        io_in_valid  = (k >= vin);
        io_out_ready = (k >= vout);
        irq          = (k >= virq);
    endtask

    // Runs n checked cycles from reset release, then re-asserts reset.
    task automatic run(input string nm, input logic [10:0] c, input int n,
                       input int vin = 999, input int vout = 999,
                       input int virq = 999, input bit ien = 1'b0);
        tname = nm;
        controle = c;
        irq_enable = ien;
        @(posedge clock); #1;
        reset = 1'b0;
        chk_en = 1'b1;
        drive(0, vin, vout, virq);
        for (int k = 1; k < n; k++) begin
            @(posedge clock); #1;
            drive(k, vin, vout, virq);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        chk_en = 1'b0;
        drive(0, 999, 999, 999);
        check_drained();
    endtask

    initial begin
        cur_pt = '0;
        // Reset state: no strobes, alu_sel 0, not busy.
        @(posedge clock); #1;
        push('0);
        chk_en = 1'b1;
        @(posedge clock); #1;
        chk_en = 1'b0;
        check_drained();

        push(F); push(b(0,4)); push(b(0,4)); push(b(RW,4)); push(b(PC,4)); push(F);
        run("add", 11'h005, 6);

        push(F); push(b(0,4)); push(b(0,6), 8); push(b(RW,4)); push(b(PC,4)); push(F);
        run("udiv", 11'h00F, 13);

        push(F); push(b(0,4)); push(b(0,5), 2); push(b(RW,4)); push(b(PC,4)); push(F);
        run("mul", 11'h00E, 7);

        push(F); push(b(0,4)); push(b(0,0)); push(b(0,4)); push(b(PC,4)); push(F);
        run("tst", 11'h008, 6);

        push(F); push(b(0,4)); push(b(0,3)); push(b(0,4)); push(b(PC,4)); push(F);
        run("cmp", 11'h00A, 6);

        push(F); push(b(0,4)); push(b(0,2)); push(b(RW,4)); push(b(PC,4)); push(F);
        run("orr", 11'h00C, 6);

        push(F); push(b(0,4)); push(b(0,4)); push(b(M2R,4)); push(b(M2R|RW,4));
        push(b(PC,4)); push(F);
        run("load", 11'h240, 7);

        push(F); push(b(0,4)); push(b(0,4)); push(b(MW,4)); push(b(PC,4)); push(F);
        run("store", 11'h200, 6);

        // Branch with i/s/link set; irq raised in DECODE is taken after RETIRE.
        cur_pt = PI | PS | PL;
        push(F); push(b(0,4)); push(b(0,4)); push(b(JMP,4)); push(b(ACK,4)); push(F);
        run("branch_irq", 11'h5A0, 6, 999, 999, 1, 1'b1);
        cur_pt = '0;

        push(F); push(b(0,4)); push(b(0,4)); push(b(JMP,4)); push(F);
        run("branch_irq_masked", 11'h400, 5, 999, 999, 1, 1'b0);

        // IN: valid arrives at cycle 7, ready held cycles 2..7.
        push(F); push(b(0,4)); push(b(IRDY,4), 5); push(b(IRDY|RW,4)); push(b(PC,4)); push(F);
        run("in_delayed", 11'h601, 10, 7);

        push(F); push(b(0,4)); push(b(OVAL,4)); push(b(PC,4)); push(F);
        run("out_ready", 11'h602, 5, 999, 0);

        push(F); push(b(0,4)); push(b(OVAL,4), 3); push(b(PC,4)); push(F);
        run("out_delayed", 11'h602, 7, 999, 4);

        push(F); push(b(0,4)); push(b(PC|ILL,4)); push(F);
        run("illegal_sys", 11'h60F, 4);

        push(F); push(b(0,4)); push(b(PC|ILL,4)); push(F);
        run("illegal_alu", 11'h000, 4);

        push(F); push(b(0,4)); push(b(PC,4)); push(F);
        run("nop", 11'h600, 4);

        push(F); push(b(0,4)); push(b(FIN,4)); push(b(PC,4)); push(F);
        run("finish", 11'h603, 5);

        push(F); push(b(0,4)); push(b(RBL,4)); push(b(PC,4)); push(F);
        run("sbl", 11'h604, 5);

        push(F); push(b(0,4)); push(b(INTW,4)); push(b(PC,4)); push(F);
        run("sir", 11'h605, 5);

        // Reset during the UDIV wait: reset cycle quiet (still busy), then FETCH.
        tname = "reset_mid_udiv";
        controle = 11'h00F;
        push(F); push(b(0,4)); push(b(0,6), 3); push(BSY); push('0);
        @(posedge clock); #1;
        reset = 1'b0;
        chk_en = 1'b1;
        repeat (5) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(posedge clock); #1;
        chk_en = 1'b0;
        check_drained();

        push(F); push(b(0,4)); push(b(0,4)); push(b(RW,4)); push(b(PC,4)); push(F);
        run("add_after_reset", 11'h005, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
